// File: rtl/cmp_pipe_unit_if.sv
// Compare unit issue/result bus.
// RS and CDB side drive master; the unit is slave.
interface cmp_pipe_unit_if #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic             in_is_br;
  logic [2:0]       in_funct3;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_taken;
  logic             out_is_br;
  logic             out_err;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_is_br, in_funct3,
    output in_a, in_b, in_tag, out_ready,
    input  in_ready, out_valid, out_data,
    input  out_taken, out_is_br, out_err, out_tag
  );

  modport slave (
    input  in_valid, in_is_br, in_funct3,
    input  in_a, in_b, in_tag, out_ready,
    output in_ready, out_valid, out_data,
    output out_taken, out_is_br, out_err, out_tag
  );
endinterface

// File: rtl/cmp_pipe_unit.sv
// Pipelined RV32I branch / slt compare unit.
// Tag-carrying elastic pipe with flush, feeds the CDB.
module cmp_pipe_unit #(
  parameter int WIDTH  = 32,
  parameter int TAG_W  = 4,
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  cmp_pipe_unit_if.slave bus
);

  typedef struct packed {
    logic             is_br;
    logic             err;
    logic             taken;
    logic             res;
    logic [TAG_W-1:0] tag;
  } pay_t;

  logic [STAGES-1:0] r_vld;
  pay_t              r_pay [STAGES];
  logic [STAGES-1:0] w_adv;
  logic [STAGES-1:0] w_lo;
  logic              w_eq;
  logic              w_lts;
  logic              w_ltu;
  logic              w_res;
  logic              w_err;
  pay_t              w_new;

  assign w_eq  = bus.in_a == bus.in_b;
  assign w_lts = $signed(bus.in_a) < $signed(bus.in_b);
  assign w_ltu = bus.in_a < bus.in_b;

  // Decode funct3 into the compare result or an illegal flag.
  always_comb begin
    w_res = 1'b0;
    w_err = 1'b0;
    if (bus.in_is_br) begin
      unique case (bus.in_funct3)
        3'b000:  w_res = w_eq;
        3'b001:  w_res = !w_eq;
        3'b100:  w_res = w_lts;
        3'b101:  w_res = !w_lts;
        3'b110:  w_res = w_ltu;
        3'b111:  w_res = !w_ltu;
        default: w_err = 1'b1;
      endcase
    end else begin
      unique case (bus.in_funct3)
        3'b010:  w_res = w_lts;
        3'b011:  w_res = w_ltu;
        default: w_err = 1'b1;
      endcase
    end
  end

  assign w_new.is_br = bus.in_is_br;
  assign w_new.err   = w_err;
  assign w_new.taken = bus.in_is_br & w_res;
  assign w_new.res   = w_res;
  assign w_new.tag   = bus.in_tag;

  // Stage i moves if any stage at or after it is empty, or the CDB takes.
  always_comb begin
    w_adv = '0;
    w_lo  = '0;
    for (int i = 0; i < STAGES; i++) begin
      w_lo     = STAGES'((1 << i) - 1);
      w_adv[i] = bus.out_ready || !(&(r_vld | w_lo));
    end
  end

  assign bus.in_ready = !flush && w_adv[0];

  // Capture into stage 0 and shift payloads down the pipe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_vld <= '0;
      for (int i = 0; i < STAGES; i++) begin
        r_pay[i] <= '0;
      end
    end else if (flush) begin
      r_vld <= '0;
    end else begin
      if (w_adv[0]) begin
        r_vld[0] <= bus.in_valid;
        r_pay[0] <= w_new;
      end
      for (int i = 1; i < STAGES; i++) begin
        if (w_adv[i]) begin
          r_vld[i] <= r_vld[i-1];
          r_pay[i] <= r_pay[i-1];
        end
      end
    end
  end

  assign bus.out_valid = r_vld[STAGES-1];
  assign bus.out_data  = {{(WIDTH-1){1'b0}}, r_pay[STAGES-1].res};
  assign bus.out_taken = r_pay[STAGES-1].taken;
  assign bus.out_is_br = r_pay[STAGES-1].is_br;
  assign bus.out_err   = r_pay[STAGES-1].err;
  assign bus.out_tag   = r_pay[STAGES-1].tag;

endmodule

// File: tb/tb_cmp_pipe_unit.sv
// Bench for cmp_pipe_unit at STAGES 1, 2 and 4.
// Queue reference model plus directed latency steps.
module tb_cmp_pipe_unit;
  localparam int W = 32;
  localparam int T = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic flush = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   ndel = 0;

  always #5 clk = ~clk;

  cmp_pipe_unit_if #(.WIDTH(W), .TAG_W(T)) b1 ();
  cmp_pipe_unit_if #(.WIDTH(W), .TAG_W(T)) b2 ();
  cmp_pipe_unit_if #(.WIDTH(W), .TAG_W(T)) b4 ();

  cmp_pipe_unit #(.WIDTH(W), .TAG_W(T), .STAGES(1)) u1 (
    .clk(clk), .rst(rst), .flush(flush), .bus(b1.slave));
  cmp_pipe_unit #(.WIDTH(W), .TAG_W(T), .STAGES(2)) u2 (
    .clk(clk), .rst(rst), .flush(flush), .bus(b2.slave));
  cmp_pipe_unit #(.WIDTH(W), .TAG_W(T), .STAGES(4)) u4 (
    .clk(clk), .rst(rst), .flush(flush), .bus(b4.slave));

  task automatic chk(input string tg, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tg, obs, exp);
    end
  endtask

  // {tag, is_br, err, taken, data}
  function automatic logic [38:0] model(input logic br,
      input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
      input logic [3:0] tg);
    logic r;
    logic e;
    r = 1'b0;
    e = 1'b0;
    if (br) begin
      case (f)
        3'd0: r = (a == b);
        3'd1: r = (a != b);
        3'd4: r = ($signed(a) < $signed(b));
        3'd5: r = ($signed(a) >= $signed(b));
        3'd6: r = (a < b);
        3'd7: r = (a >= b);
        default: e = 1'b1;
      endcase
    end else begin
      case (f)
        3'd2: r = ($signed(a) < $signed(b));
        3'd3: r = (a < b);
        default: e = 1'b1;
      endcase
    end
    return {tg, br, e, br & r, 31'd0, r};
  endfunction

  logic [38:0] pay2;
  assign pay2 = {b2.out_tag, b2.out_is_br, b2.out_err,
                 b2.out_taken, b2.out_data};

  logic [38:0] q[$];
  logic        hold_v = 1'b0;
  logic [38:0] hold_p = '0;
  logic [38:0] e_pay;

  always @(negedge clk) begin
    if (!rst) begin
      q.delete();
      hold_v = 1'b0;
    end else begin
      if (hold_v) chk("hold", {b2.out_valid, pay2}, {1'b1, hold_p});
      if (b2.out_valid && b2.out_ready && !flush) begin
        chk("deliv_q", q.size() != 0, 1);
        if (q.size() != 0) begin
          e_pay = q.pop_front();
          chk("deliv", pay2, e_pay);
          ndel++;
        end
      end
      if (b2.in_valid && b2.in_ready)
        q.push_back(model(b2.in_is_br, b2.in_funct3, b2.in_a,
                          b2.in_b, b2.in_tag));
      if (flush) q.delete();
      hold_v = b2.out_valid && !b2.out_ready && !flush;
      hold_p = pay2;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic op2(input logic br, input logic [2:0] f,
                     input logic [31:0] a, input logic [31:0] b,
                     input logic [3:0] tg);
    b2.in_is_br  = br;
    b2.in_funct3 = f;
    b2.in_a      = a;
    b2.in_b      = b;
    b2.in_tag    = tg;
  endtask

  task automatic rop2(input logic [3:0] tg);
    logic [31:0] a;
    a = $urandom;
    op2(1'($urandom), 3'($urandom), a,
        ($urandom % 4 == 0) ? a : $urandom, tg);
  endtask

  logic        s_br [6];
  logic [2:0]  s_f  [6];
  logic [31:0] s_a  [6];
  logic [31:0] s_b  [6];
  logic        s_d  [6];
  logic        s_t  [6];
  int          sent;
  int          d0;

  initial begin
    s_br = '{1, 1, 1, 1, 0, 0};
    s_f  = '{3'b100, 3'b110, 3'b101, 3'b001, 3'b010, 3'b011};
    s_a  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd5, 32'd7,
             32'h8000_0000, 32'h8000_0000};
    s_b  = '{32'd1, 32'd1, 32'd5, 32'd7, 32'd0, 32'd0};
    s_d  = '{1, 0, 1, 0, 1, 0};
    s_t  = '{1, 0, 1, 0, 0, 0};

    b1.in_valid = 0; b1.in_is_br = 0; b1.in_funct3 = 0;
    b1.in_a = 0; b1.in_b = 0; b1.in_tag = 0; b1.out_ready = 1;
    b4.in_valid = 0; b4.in_is_br = 0; b4.in_funct3 = 0;
    b4.in_a = 0; b4.in_b = 0; b4.in_tag = 0; b4.out_ready = 1;
    b2.out_ready = 1;
    b2.in_valid = 1;
    op2(1, 3'b000, 32'd3, 32'd3, 4'd0);

    // reset held with in_valid asserted
    repeat (2) @(negedge clk);
    chk("rst_ov2", b2.out_valid, 0);
    chk("rst_ir2", b2.in_ready, 1);
    chk("rst_ov1", b1.out_valid, 0);
    chk("rst_ov4", b4.out_valid, 0);
    chk("rst_pay2", pay2, 0);
    tick();
    rst = 1;
    tick();
    b2.in_valid = 0;
    @(negedge clk);
    chk("lat_early", b2.out_valid, 0);
    @(negedge clk);
    chk("lat_ov", b2.out_valid, 1);
    chk("lat_tag", b2.out_tag, 0);
    tick();

    // directed sweep, tags 0..5 back to back
    for (int k = 0; k < 8; k++) begin
      b2.in_valid = (k < 6);
      if (k < 6) op2(s_br[k], s_f[k], s_a[k], s_b[k], 4'(k));
      @(negedge clk);
      chk("sw_ir", b2.in_ready, 1);
      if (k >= 2) begin
        chk("sw_ov", b2.out_valid, 1);
        chk("sw_tag", b2.out_tag, k - 2);
        chk("sw_data", b2.out_data, {31'd0, s_d[k-2]});
        chk("sw_taken", b2.out_taken, s_t[k-2]);
      end
      tick();
    end
    b2.in_valid = 0;

    // backpressure: six ops, CDB stalled for four cycles
    sent = 0;
    d0 = ndel;
    for (int c = 0; c < 40; c++) begin
      b2.out_ready = (c >= 4);
      b2.in_valid  = (sent < 6);
      rop2(4'(sent + 8));
      @(negedge clk);
      if (c == 2 || c == 3) begin
        chk("bp_ir", b2.in_ready, 0);
        chk("bp_tag", b2.out_tag, 8);
      end
      if (c == 3) chk("bp_cnt", sent, 2);
      if (b2.in_valid && b2.in_ready) sent++;
      tick();
      if (sent == 6 && c > 12) break;
    end
    b2.in_valid = 0;
    chk("bp_sent", sent, 6);
    repeat (4) tick();
    chk("bp_del", ndel - d0, 6);
    chk("bp_q", q.size(), 0);

    // bubble collapse
    b2.out_ready = 0;
    b2.in_valid = 1;
    rop2(4'd1);
    @(negedge clk);
    chk("bb_ir0", b2.in_ready, 1);
    tick();
    b2.in_valid = 0;
    tick();
    b2.in_valid = 1;
    rop2(4'd2);
    @(negedge clk);
    chk("bb_ir1", b2.in_ready, 1);
    tick();
    b2.in_valid = 0;
    @(negedge clk);
    chk("bb_full", b2.in_ready, 0);
    chk("bb_ov", b2.out_valid, 1);
    chk("bb_tag", b2.out_tag, 1);
    tick();
    b2.out_ready = 1;
    repeat (3) tick();
    chk("bb_q", q.size(), 0);

    // flush with two ops in flight
    b2.in_valid = 1;
    rop2(4'd4);
    tick();
    rop2(4'd5);
    tick();
    flush = 1;
    rop2(4'd7);
    @(negedge clk);
    chk("fl_ir", b2.in_ready, 0);
    tick();
    flush = 0;
    b2.in_valid = 0;
    @(negedge clk);
    chk("fl_ov", b2.out_valid, 0);
    tick();
    @(negedge clk);
    chk("fl_ov2", b2.out_valid, 0);
    tick();
    b2.in_valid = 1;
    op2(0, 3'b011, 32'd1, 32'd2, 4'd6);
    tick();
    b2.in_valid = 0;
    @(negedge clk);
    chk("fl_new0", b2.out_valid, 0);
    @(negedge clk);
    chk("fl_new1", b2.out_valid, 1);
    chk("fl_newtag", b2.out_tag, 6);
    chk("fl_newd", b2.out_data, 1);
    tick();

    // illegal funct3 at all three depths
    b1.in_valid = 1; b1.in_is_br = 1; b1.in_funct3 = 3'b010;
    b1.in_a = 32'd4; b1.in_b = 32'd4; b1.in_tag = 4'd9;
    b4.in_valid = 1; b4.in_is_br = 1; b4.in_funct3 = 3'b010;
    b4.in_a = 32'd4; b4.in_b = 32'd4; b4.in_tag = 4'd9;
    b2.in_valid = 1;
    op2(1, 3'b010, 32'd4, 32'd4, 4'd9);
    tick();
    b1.in_valid = 0;
    b2.in_valid = 0;
    b4.in_valid = 0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      chk("il_ov1", b1.out_valid, i == 1);
      chk("il_ov2", b2.out_valid, i == 2);
      chk("il_ov4", b4.out_valid, i == 4);
      if (i == 1)
        chk("il_pay1", {b1.out_err, b1.out_taken, b1.out_data, b1.out_tag},
            {1'b1, 1'b0, 32'd0, 4'd9});
      if (i == 2)
        chk("il_pay2", {b2.out_err, b2.out_taken, b2.out_data, b2.out_tag},
            {1'b1, 1'b0, 32'd0, 4'd9});
      if (i == 4)
        chk("il_pay4", {b4.out_err, b4.out_taken, b4.out_data, b4.out_tag},
            {1'b1, 1'b0, 32'd0, 4'd9});
    end
    tick();

    // random traffic against the queue model
    for (int c = 0; c < 400; c++) begin
      b2.in_valid  = ($urandom % 4 != 0);
      b2.out_ready = ($urandom % 3 != 0);
      flush        = ($urandom % 30 == 0);
      rop2(4'($urandom));
      tick();
    end
    flush = 0;
    b2.in_valid = 0;
    b2.out_ready = 1;
    repeat (4) tick();
    chk("rnd_q", q.size(), 0);

    // async reset with the pipe full
    b2.out_ready = 0;
    b2.in_valid = 1;
    rop2(4'd3);
    repeat (3) tick();
    b2.in_valid = 0;
    #2;
    rst = 0;
    #1;
    chk("ar_ov", b2.out_valid, 0);
    chk("ar_ir", b2.in_ready, 1);
    tick();
    rst = 1;
    b2.out_ready = 1;
    @(negedge clk);
    chk("ar_post", b2.out_valid, 0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
endmodule
